// File: rtl/mem_stage.sv
// Memory-access stage: latches the EXE->MEM bus, drives the synchronous-read data RAM,
// and builds the MEM->WB bus. Define MEM_ADDR_CHECK_EN to flag and suppress misaligned word accesses.
module mem_stage (
  input  logic         clk,
  input  logic         resetn,
  input  logic         EXE_over,
  input  logic [154:0] EXE_MEM_bus,
  output logic         MEM_allow_in,
  output logic         MEM_valid,
  output logic         MEM_over,
  input  logic         WB_allow_in,
  input  logic         cancel,
  output logic [118:0] MEM_WB_bus,
  output logic [31:0]  dm_addr,
  output logic [3:0]   dm_wen,
  output logic [31:0]  dm_wdata,
  input  logic [31:0]  dm_rdata,
  output logic [4:0]   MEM_wdest,
  output logic [31:0]  MEM_pc,
  output logic         addr_err
);

  typedef enum logic {StAddr, StData} state_e;

  state_e         r_state, w_state_d;
  logic           r_valid, w_valid_d;
  logic           r_store_done, w_store_done_d;
  logic [154:0]   r_bus, w_bus_d;

  logic           w_inst_load, w_inst_store, w_ls_word, w_lb_sign;
  logic [31:0]    w_store_data, w_exe_result, w_lo_result;
  logic           w_hi_write, w_lo_write, w_wen;
  logic [4:0]     w_wdest;
  logic           w_mfhi, w_mflo, w_mtc0, w_mfc0;
  logic [7:0]     w_cp0r_addr;
  logic           w_syscall, w_eret, w_overflow;
  logic [31:0]    w_pc;

  logic           w_latch, w_store_fire;
  logic [3:0]     w_byte_wen;
  logic [7:0]     w_load_byte;
  logic [31:0]    w_load_data, w_mem_result;

  assign {w_inst_load, w_inst_store, w_ls_word, w_lb_sign, w_store_data, w_exe_result,
          w_lo_result, w_hi_write, w_lo_write, w_wen, w_wdest, w_mfhi, w_mflo, w_mtc0, w_mfc0,
          w_cp0r_addr, w_syscall, w_eret, w_overflow, w_pc} = r_bus;

  assign MEM_valid    = r_valid;
  assign MEM_over     = r_valid & (~w_inst_load | (r_state == StData));
  assign MEM_allow_in = ~r_valid | (MEM_over & WB_allow_in);
  assign w_latch      = MEM_allow_in & EXE_over & ~cancel;
  // Guarded by r_store_done so a store held in place by a WB stall writes only once.
  assign w_store_fire = r_valid & w_inst_store & ~r_store_done & ~cancel;

`ifdef MEM_ADDR_CHECK_EN
  assign addr_err = r_valid & w_ls_word & (w_inst_load | w_inst_store) &
                    (w_exe_result[1:0] != 2'b00);
`else
  assign addr_err = 1'b0;
`endif

  always_comb begin
    w_valid_d      = r_valid;
    w_state_d      = r_state;
    w_store_done_d = r_store_done;
    w_bus_d        = r_bus;
    if (w_store_fire) w_store_done_d = 1'b1;
    if (cancel) begin
      w_valid_d = 1'b0;
      w_state_d = StAddr;
    end else if (w_latch) begin
      w_bus_d        = EXE_MEM_bus;
      w_valid_d      = 1'b1;
      w_state_d      = StAddr;
      w_store_done_d = 1'b0;
    end else if (MEM_allow_in) begin
      w_valid_d = 1'b0;
      w_state_d = StAddr;
    end else if ((r_state == StAddr) && r_valid && w_inst_load) begin
      w_state_d = StData;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_valid      <= 1'b0;
      r_state      <= StAddr;
      r_store_done <= 1'b0;
      r_bus        <= '0;
    end else begin
      r_valid      <= w_valid_d;
      r_state      <= w_state_d;
      r_store_done <= w_store_done_d;
      r_bus        <= w_bus_d;
    end
  end

  assign dm_addr    = w_exe_result;
  assign w_byte_wen = 4'b0001 << w_exe_result[1:0];
  assign dm_wen     = (w_store_fire & ~addr_err) ? (w_ls_word ? 4'b1111 : w_byte_wen) : 4'b0000;
  assign dm_wdata   = w_ls_word ? w_store_data : {4{w_store_data[7:0]}};

  always_comb begin
    w_load_byte = dm_rdata[7:0];
    case (w_exe_result[1:0])
      2'd0:    w_load_byte = dm_rdata[7:0];
      2'd1:    w_load_byte = dm_rdata[15:8];
      2'd2:    w_load_byte = dm_rdata[23:16];
      default: w_load_byte = dm_rdata[31:24];
    endcase
  end

  assign w_load_data  = w_ls_word ? dm_rdata
                                  : {{24{w_lb_sign & w_load_byte[7]}}, w_load_byte};
  assign w_mem_result = w_inst_load ? w_load_data : w_exe_result;

  assign MEM_WB_bus = {w_wen & ~addr_err, w_wdest, w_mem_result, w_lo_result, w_hi_write,
                       w_lo_write, w_mfhi, w_mflo, w_mtc0, w_mfc0, w_cp0r_addr, w_syscall,
                       w_eret, w_overflow, w_pc};

  assign MEM_wdest = w_wdest & {5{r_valid}};
  assign MEM_pc    = w_pc;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a small synchronous-read RAM model.
// Misaligned-access expectations follow MEM_ADDR_CHECK_EN.
module tb_mem_stage;

  localparam logic [31:0] LoC = 32'h1234_5678;

  logic         clk = 1'b0;
  logic         resetn;
  logic         EXE_over;
  logic [154:0] EXE_MEM_bus;
  logic         MEM_allow_in, MEM_valid, MEM_over;
  logic         WB_allow_in, cancel;
  logic [118:0] MEM_WB_bus;
  logic [31:0]  dm_addr, dm_wdata, dm_rdata, MEM_pc;
  logic [3:0]   dm_wen;
  logic [4:0]   MEM_wdest;
  logic         addr_err;

  int n_assert = 0;
  int n_fail   = 0;
  int n_wen_pulses = 0;
  int pulses_before;
  logic done = 1'b0;

  logic [31:0] ram [0:63] = '{default: 32'h0};

  always #5 clk = ~clk;

  mem_stage dut (
    .clk          (clk),
    .resetn       (resetn),
    .EXE_over     (EXE_over),
    .EXE_MEM_bus  (EXE_MEM_bus),
    .MEM_allow_in (MEM_allow_in),
    .MEM_valid    (MEM_valid),
    .MEM_over     (MEM_over),
    .WB_allow_in  (WB_allow_in),
    .cancel       (cancel),
    .MEM_WB_bus   (MEM_WB_bus),
    .dm_addr      (dm_addr),
    .dm_wen       (dm_wen),
    .dm_wdata     (dm_wdata),
    .dm_rdata     (dm_rdata),
    .MEM_wdest    (MEM_wdest),
    .MEM_pc       (MEM_pc),
    .addr_err     (addr_err)
  );

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (dm_wen[b]) ram[dm_addr[7:2]][8*b +: 8] <= dm_wdata[8*b +: 8];
    dm_rdata <= ram[dm_addr[7:2]];
    if (resetn && dm_wen != 4'd0) n_wen_pulses++;
  end

  function automatic logic [154:0] mk_exe(input logic ld, input logic st, input logic wd,
                                          input logic sg, input logic [31:0] sdata,
                                          input logic [31:0] res, input logic wen,
                                          input logic [4:0] wdest, input logic [31:0] pc);
    return {ld, st, wd, sg, sdata, res, LoC, 1'b1, 1'b0, wen, wdest,
            1'b0, 1'b1, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b1, 1'b0, pc};
  endfunction

  function automatic logic [118:0] mk_wb(input logic wen, input logic [4:0] wdest,
                                         input logic [31:0] mres, input logic [31:0] pc);
    return {wen, wdest, mres, LoC, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h5A,
            1'b0, 1'b1, 1'b0, pc};
  endfunction

  task automatic check(input string tag, input logic [154:0] obs, input logic [154:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    if (!done) begin
      n_fail++;
      $error("FAIL timeout: test did not finish");
      $finish;
    end
  end

  initial begin
    resetn      = 1'b0;
    EXE_over    = 1'b0;
    EXE_MEM_bus = '0;
    WB_allow_in = 1'b1;
    cancel      = 1'b0;
    tick();
    tick();
    check("rst_valid", MEM_valid, 1'b0);
    check("rst_over", MEM_over, 1'b0);
    check("rst_allow", MEM_allow_in, 1'b1);
    check("rst_wen", dm_wen, 4'h0);
    check("rst_wdest", MEM_wdest, 5'd0);
    check("rst_addr_err", addr_err, 1'b0);
    check("rst_wb_bus", MEM_WB_bus, 119'd0);

    // sw 0xDEADBEEF to 0x10
    resetn      = 1'b1;
    EXE_over    = 1'b1;
    EXE_MEM_bus = mk_exe(1'b0, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF, 32'h10, 1'b0, 5'd0, 32'h100);
    tick();
    EXE_over = 1'b0;
    #1;
    check("sw_valid", MEM_valid, 1'b1);
    check("sw_over", MEM_over, 1'b1);
    check("sw_wen", dm_wen, 4'hF);
    check("sw_wdata", dm_wdata, 32'hDEADBEEF);
    check("sw_addr", dm_addr, 32'h10);
    check("sw_pc", MEM_pc, 32'h100);
    check("sw_wb_bus", MEM_WB_bus, mk_wb(1'b0, 5'd0, 32'h10, 32'h100));
    tick();
    check("sw_drained", MEM_valid, 1'b0);
    check("sw_ram", ram[4], 32'hDEADBEEF);

    // lw from 0x10: two-cycle latency
    EXE_over    = 1'b1;
    EXE_MEM_bus = mk_exe(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h10, 1'b1, 5'd5, 32'h104);
    tick();
    EXE_over = 1'b0;
    #1;
    check("lw_c1_over", MEM_over, 1'b0);
    check("lw_c1_allow", MEM_allow_in, 1'b0);
    check("lw_c1_wen", dm_wen, 4'h0);
    check("lw_wdest", MEM_wdest, 5'd5);
    tick();
    check("lw_c2_over", MEM_over, 1'b1);
    check("lw_wb_bus", MEM_WB_bus, mk_wb(1'b1, 5'd5, 32'hDEADBEEF, 32'h104));
    tick();
    check("lw_drained", MEM_valid, 1'b0);
    check("lw_wdest_idle", MEM_wdest, 5'd0);

    // sb 0x85 to 0x22
    EXE_over    = 1'b1;
    EXE_MEM_bus = mk_exe(1'b0, 1'b1, 1'b0, 1'b0, 32'h12345685, 32'h22, 1'b0, 5'd0, 32'h108);
    tick();
    EXE_over = 1'b0;
    #1;
    check("sb_wen", dm_wen, 4'b0100);
    check("sb_wdata", dm_wdata, 32'h85858585);
    tick();
    check("sb_ram", ram[8], 32'h00850000);

    // lb then lbu back-to-back from 0x22
    EXE_over    = 1'b1;
    EXE_MEM_bus = mk_exe(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h22, 1'b1, 5'd6, 32'h10C);
    tick();
    EXE_over = 1'b0;
    #1;
    check("lb_c1_over", MEM_over, 1'b0);
    tick();
    EXE_over    = 1'b1;
    EXE_MEM_bus = mk_exe(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h22, 1'b1, 5'd7, 32'h110);
    #1;
    check("lb_over", MEM_over, 1'b1);
    check("lb_allow", MEM_allow_in, 1'b1);
    check("lb_wb_bus", MEM_WB_bus, mk_wb(1'b1, 5'd6, 32'hFFFFFF85, 32'h10C));
    tick();
    EXE_over = 1'b0;
    #1;
    check("lbu_refill_valid", MEM_valid, 1'b1);
    check("lbu_refill_pc", MEM_pc, 32'h110);
    check("lbu_c1_over", MEM_over, 1'b0);
    tick();
    check("lbu_wb_bus", MEM_WB_bus, mk_wb(1'b1, 5'd7, 32'h00000085, 32'h110));
    tick();

    // sw stalled by write-back for 5 cycles, with a competing instruction offered
    WB_allow_in   = 1'b0;
    EXE_over      = 1'b1;
    EXE_MEM_bus   = mk_exe(1'b0, 1'b1, 1'b1, 1'b0, 32'hCAFEF00D, 32'h30, 1'b0, 5'd0, 32'h200);
    pulses_before = n_wen_pulses;
    tick();
    EXE_MEM_bus = mk_exe(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h3C, 1'b1, 5'd1, 32'h204);
    #1;
    check("stall_c1_wen", dm_wen, 4'hF);
    tick();
    check("stall_c2_wen", dm_wen, 4'h0);
    tick();
    tick();
    tick();
    check("stall_allow", MEM_allow_in, 1'b0);
    check("stall_valid", MEM_valid, 1'b1);
    check("stall_wb_bus", MEM_WB_bus, mk_wb(1'b0, 5'd0, 32'h30, 32'h200));
    check("stall_pulses", n_wen_pulses - pulses_before, 1);
    check("stall_ram", ram[12], 32'hCAFEF00D);
    EXE_over    = 1'b0;
    WB_allow_in = 1'b1;
    tick();
    check("stall_drained", MEM_valid, 1'b0);

    // cancel while a load sits in the data state, with EXE offering a store
    EXE_over    = 1'b1;
    EXE_MEM_bus = mk_exe(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h10, 1'b1, 5'd9, 32'h300);
    tick();
    EXE_over = 1'b0;
    tick();
    cancel      = 1'b1;
    EXE_over    = 1'b1;
    EXE_MEM_bus = mk_exe(1'b0, 1'b1, 1'b1, 1'b0, 32'hBAD0BAD0, 32'h34, 1'b0, 5'd0, 32'h400);
    tick();
    cancel   = 1'b0;
    EXE_over = 1'b0;
    #1;
    check("cancel_valid", MEM_valid, 1'b0);
    check("cancel_over", MEM_over, 1'b0);
    check("cancel_no_latch_pc", MEM_pc, 32'h300);
    check("cancel_wen", dm_wen, 4'h0);

    // cancel on the cycle a store would write
    WB_allow_in = 1'b0;
    EXE_over    = 1'b1;
    tick();
    EXE_over = 1'b0;
    cancel   = 1'b1;
    #1;
    check("cancel_store_wen", dm_wen, 4'h0);
    tick();
    cancel      = 1'b0;
    WB_allow_in = 1'b1;
    #1;
    check("cancel_store_valid", MEM_valid, 1'b0);
    tick();
    check("cancel_store_ram", ram[13], 32'h0);

    // reset during the data state of a load
    EXE_over    = 1'b1;
    EXE_MEM_bus = mk_exe(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h30, 1'b1, 5'd3, 32'h500);
    tick();
    EXE_over = 1'b0;
    tick();
    check("rstmid_pre_over", MEM_over, 1'b1);
    resetn = 1'b0;
    tick();
    check("rstmid_valid", MEM_valid, 1'b0);
    check("rstmid_over", MEM_over, 1'b0);
    check("rstmid_allow", MEM_allow_in, 1'b1);
    check("rstmid_wdest", MEM_wdest, 5'd0);
    check("rstmid_wb_bus", MEM_WB_bus, 119'd0);
    check("rstmid_pc", MEM_pc, 32'h0);
    resetn = 1'b1;
    tick();

    // misaligned sw to 0x13
    EXE_over    = 1'b1;
    EXE_MEM_bus = mk_exe(1'b0, 1'b1, 1'b1, 1'b0, 32'h11223344, 32'h13, 1'b1, 5'd2, 32'h600);
    tick();
    EXE_over = 1'b0;
    #1;
`ifdef MEM_ADDR_CHECK_EN
    check("mis_addr_err", addr_err, 1'b1);
    check("mis_wen", dm_wen, 4'h0);
    check("mis_wb_wen", MEM_WB_bus[118], 1'b0);
`else
    check("mis_addr_err", addr_err, 1'b0);
    check("mis_wen", dm_wen, 4'hF);
    check("mis_wb_wen", MEM_WB_bus[118], 1'b1);
`endif
    tick();

    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
